// File: rtl/spi_ctrl_pkg.sv
// Purpose : shared types and default timing for the SPI bus arbiter slice.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: arbiter state enum, SPI mode struct, default timing constants,
//           max3() helper used to size the shared timing counter.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DESEL = 3'd5
  } arb_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_CS_SETUP = 4;
  localparam int DEF_CS_HOLD  = 4;
  localparam int DEF_CS_IDLE  = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose : round-robin pick of the first set request at or after a pointer.
// Latency : purely combinational; the pointer register lives in the parent.
// Backpr. : none; o_any is low when no request is set.
// Ports   : i_req request vector, i_ptr search start index,
//           o_gnt_oh one-hot winner, o_gnt_idx winner index, o_any any request.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt_oh,
  output logic [IW-1:0]    o_gnt_idx,
  output logic             o_any
);

  always_comb begin
    int j;
    j         = 0;
    o_any     = 1'b0;
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    // Walk N_REQ slots starting at the pointer, wrapping; first hit wins.
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(i_ptr) + i) % N_REQ;
      if (!o_any && i_req[j]) begin
        o_any       = 1'b1;
        o_gnt_oh[j] = 1'b1;
        o_gnt_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Purpose : shares one spi_master between N_REQ chip-select owners, one burst per grant.
// Latency : CS low -> first m_start = CS_SETUP+1 clk; m_done -> rx_valid = 1 clk;
//           last m_done -> CS high = CS_HOLD+1 clk; CS high -> next grant >= CS_IDLE clk.
// Backpr. : bytes move only when tx_valid && m_tx_ready; a stalled owner keeps CS low.
// Ports   : req/req_cpol/req_cpha/tx_* from requesters; tx_accept/rx_* back to them;
//           gnt/busy/cs_n status and pins; m_* connect to spi_master.
module spi_bus_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD,
  parameter int CS_IDLE  = DEF_CS_IDLE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      req_cpol,
  input  logic [N_REQ-1:0]      req_cpha,
  input  logic [N_REQ-1:0]      tx_valid,
  input  logic [N_REQ-1:0][7:0] tx_data,
  input  logic [N_REQ-1:0]      tx_last,
  output logic [N_REQ-1:0]      tx_accept,
  output logic [N_REQ-1:0]      rx_valid,
  output logic [7:0]            rx_data,
  output logic [N_REQ-1:0]      gnt,
  output logic                  busy,
  output logic [N_REQ-1:0]      cs_n,
  output logic                  m_start,
  output logic [7:0]            m_tx_data,
  output logic                  m_cpol,
  output logic                  m_cpha,
  input  logic [7:0]            m_rx_data,
  input  logic                  m_tx_ready,
  input  logic                  m_done
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(max3(CS_SETUP, CS_HOLD, CS_IDLE) + 1);

  arb_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_gnt_idx;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_cs_n;
  spi_mode_t        r_mode;
  logic             r_last;
  logic             r_m_start;
  logic [7:0]       r_m_tx_data;
  logic [N_REQ-1:0] r_tx_accept;
  logic [N_REQ-1:0] r_rx_valid;
  logic [7:0]       r_rx_data;

  logic [N_REQ-1:0] w_win_oh;
  logic [IW-1:0]    w_win_idx;
  logic             w_win_any;
  logic             w_setup_end;
  logic             w_hold_end;
  logic             w_idle_end;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .o_gnt_oh  (w_win_oh),
    .o_gnt_idx (w_win_idx),
    .o_any     (w_win_any)
  );

  assign w_setup_end = (r_cnt == CW'(CS_SETUP - 1));
  assign w_hold_end  = (r_cnt == CW'(CS_HOLD - 1));
  assign w_idle_end  = (r_cnt == CW'(CS_IDLE - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_gnt_idx   <= '0;
      r_gnt       <= '0;
      r_cs_n      <= '1;
      r_mode      <= '0;
      r_last      <= 1'b0;
      r_m_start   <= 1'b0;
      r_m_tx_data <= '0;
      r_tx_accept <= '0;
      r_rx_valid  <= '0;
      r_rx_data   <= '0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      r_m_start   <= 1'b0;
      r_tx_accept <= '0;
      r_rx_valid  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_any) begin
            r_gnt     <= w_win_oh;
            r_gnt_idx <= w_win_idx;
            // Mode is captured only here so SCLK idle level settles during SETUP.
            r_mode    <= '{cpol: req_cpol[w_win_idx], cpha: req_cpha[w_win_idx]};
            r_cs_n    <= ~w_win_oh;
            r_cnt     <= '0;
            r_state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_setup_end) begin
            r_cnt   <= '0;
            r_state <= ST_ISSUE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_ISSUE: begin
          if (!req[r_gnt_idx]) begin
            // Owner abandoned the burst: close CS without sending anything.
            r_cnt   <= '0;
            r_state <= ST_HOLD;
          end else if (tx_valid[r_gnt_idx] && m_tx_ready) begin
            r_m_start   <= 1'b1;
            r_m_tx_data <= tx_data[r_gnt_idx];
            r_tx_accept <= r_gnt;
            r_last      <= tx_last[r_gnt_idx];
            r_cnt       <= '0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (m_done) begin
            r_rx_data  <= m_rx_data;
            r_rx_valid <= r_gnt;
            r_cnt      <= '0;
            r_state    <= r_last ? ST_HOLD : ST_ISSUE;
          end
        end
        ST_HOLD: begin
          if (w_hold_end) begin
            r_cs_n  <= '1;
            r_gnt   <= '0;
            r_ptr   <= (r_gnt_idx == IW'(N_REQ - 1)) ? '0 : r_gnt_idx + IW'(1);
            r_cnt   <= '0;
            r_state <= ST_DESEL;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DESEL: begin
          if (w_idle_end) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_accept = r_tx_accept;
  assign rx_valid  = r_rx_valid;
  assign rx_data   = r_rx_data;
  assign gnt       = r_gnt;
  assign busy      = (r_state != ST_IDLE);
  assign cs_n      = r_cs_n;
  assign m_start   = r_m_start;
  assign m_tx_data = r_m_tx_data;
  assign m_cpol    = r_mode.cpol;
  assign m_cpha    = r_mode.cpha;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Purpose : directed self-checking bench for spi_bus_arbiter with a behavioural spi_master.
// Latency : model master raises done 4 clk after it sees m_start.
// Backpr. : model master drops tx_ready while a byte is in flight.
module tb_spi_bus_arbiter;

  localparam int N = 4;
  localparam int SETUP = 4;
  localparam int HOLD = 4;
  localparam int IDLE = 8;

  logic clk;
  logic reset;
  logic [N-1:0] req, req_cpol, req_cpha, tx_valid, tx_last;
  logic [N-1:0][7:0] tx_data;
  logic [N-1:0] tx_accept, rx_valid, gnt, cs_n;
  logic [7:0] rx_data, m_tx_data, m_rx_data;
  logic busy, m_start, m_cpol, m_cpha, m_tx_ready, m_done;

  int errors = 0;
  int checks = 0;

  spi_bus_arbiter #(.N_REQ(N), .CS_SETUP(SETUP), .CS_HOLD(HOLD), .CS_IDLE(IDLE)) dut (
    .clk(clk), .reset(reset), .req(req), .req_cpol(req_cpol), .req_cpha(req_cpha),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_accept(tx_accept),
    .rx_valid(rx_valid), .rx_data(rx_data), .gnt(gnt), .busy(busy), .cs_n(cs_n),
    .m_start(m_start), .m_tx_data(m_tx_data), .m_cpol(m_cpol), .m_cpha(m_cpha),
    .m_rx_data(m_rx_data), .m_tx_ready(m_tx_ready), .m_done(m_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural spi_master: slave answers with (sent byte ^ sl_xor).
  logic [7:0] sl_xor = 8'h00;
  logic [7:0] ltx;
  int mcnt;
  always @(posedge clk) begin
    if (!reset) begin
      m_tx_ready <= 1'b1;
      m_done     <= 1'b0;
      m_rx_data  <= 8'h00;
      mcnt       <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_start) begin
        m_tx_ready <= 1'b0;
        ltx        <= m_tx_data;
        mcnt       <= 3;
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          m_done     <= 1'b1;
          m_rx_data  <= ltx ^ sl_xor;
          m_tx_ready <= 1'b1;
        end
      end
    end
  end

  // Event log and invariant monitor, sampled on the falling edge.
  int cyc = 0;
  int inv_err = 0;
  int acc_cnt = 0;
  bit inflight = 0;
  logic [N-1:0] prev_gnt = '0;
  logic prev_busy = 1'b0;
  logic [1:0] prev_mode = 2'b00;
  int start_cyc[$], done_cyc[$], rx_cyc[$], cs_fall[$], cs_rise[$], idle_cyc[$], gnt_log[$], rx_idx[$];
  logic [7:0] mosi[$], rx_dat[$];
  logic [1:0] mode_q[$];

  function automatic int oh2idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!reset) inflight = 0;
    if (m_start) begin
      if (inflight || (&cs_n)) inv_err++;
      inflight = 1;
      start_cyc.push_back(cyc);
      mosi.push_back(m_tx_data);
      mode_q.push_back({m_cpol, m_cpha});
    end
    if (m_done) begin
      inflight = 0;
      done_cyc.push_back(cyc);
    end
    if (rx_valid != '0) begin
      rx_cyc.push_back(cyc);
      rx_dat.push_back(rx_data);
      rx_idx.push_back(oh2idx(rx_valid));
    end
    if (tx_accept != '0) acc_cnt++;
    if ((tx_accept & ~gnt) != '0) inv_err++;
    if (gnt != '0 && prev_gnt == '0) begin
      gnt_log.push_back(oh2idx(gnt));
      cs_fall.push_back(cyc);
    end
    if (gnt == '0 && prev_gnt != '0) cs_rise.push_back(cyc);
    if (!busy && prev_busy) idle_cyc.push_back(cyc);
    if ((~cs_n) != gnt) inv_err++;
    if ($countones(gnt) > 1) inv_err++;
    if (reset && prev_busy && ({m_cpol, m_cpha} != prev_mode)) inv_err++;
    prev_gnt  = gnt;
    prev_busy = busy;
    prev_mode = {m_cpol, m_cpha};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_accept(input int idx);
    bit ok;
    ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      step();
      if (tx_accept[idx]) ok = 1;
    end
    chk("accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      step();
      if (!busy) ok = 1;
    end
    chk("idle_timeout", {31'd0, ok}, 32'd1);
  endtask

  // sel: 0 = m_start count, 1 = rx_valid count, 2 = grant count.
  task automatic wait_cnt(input int sel, input int n);
    bit ok;
    int cur;
    ok = 0;
    for (int t = 0; t < 1000 && !ok; t++) begin
      cur = (sel == 0) ? start_cyc.size() : (sel == 1) ? rx_dat.size() : gnt_log.size();
      if (cur >= n) ok = 1;
      else step();
    end
    chk("event_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic do_single(input int idx, input logic cpol, input logic cpha,
                           input logic [7:0] b, input logic [7:0] ret);
    int rb;
    rb = rx_dat.size();
    sl_xor        = b ^ ret;
    req_cpol[idx] = cpol;
    req_cpha[idx] = cpha;
    tx_data[idx]  = b;
    tx_last[idx]  = 1'b1;
    tx_valid[idx] = 1'b1;
    req[idx]      = 1'b1;
    wait_accept(idx);
    tx_valid[idx] = 1'b0;
    wait_cnt(1, rb + 1);
    req[idx] = 1'b0;
    wait_idle();
  endtask

  int sb, rb, gb, fb, db, ib, ab;
  logic [7:0] burst [3];

  initial begin
    reset = 1'b0;
    req = '0; req_cpol = '0; req_cpha = '0; tx_valid = '0; tx_last = '0; tx_data = '0;
    repeat (3) step();

    // Reset state
    chk("rst_gnt", gnt, 0);
    chk("rst_cs_n", cs_n, 4'hF);
    chk("rst_busy", busy, 0);
    chk("rst_m_start", m_start, 0);
    chk("rst_tx_accept", tx_accept, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_m_tx_data", m_tx_data, 0);
    chk("rst_mode", {m_cpol, m_cpha}, 0);
    reset = 1'b1;
    repeat (2) step();

    // Single byte: A5 out, 3C back, timing windows.
    sb = start_cyc.size(); rb = rx_dat.size(); gb = gnt_log.size();
    fb = cs_fall.size(); db = done_cyc.size(); ib = idle_cyc.size();
    do_single(0, 1'b0, 1'b0, 8'hA5, 8'h3C);
    chk("t1_gnt", gnt_log[gb], 0);
    chk("t1_setup", start_cyc[sb] - cs_fall[fb], SETUP + 1);
    chk("t1_mosi", mosi[sb], 8'hA5);
    chk("t1_rx_data", rx_dat[rb], 8'h3C);
    chk("t1_rx_idx", rx_idx[rb], 0);
    chk("t1_rx_lat", rx_cyc[rb] - done_cyc[db], 1);
    chk("t1_hold", cs_rise[fb] - done_cyc[db], HOLD + 1);
    chk("t1_desel", idle_cyc[ib] - cs_rise[fb], IDLE);
    chk("t1_starts", start_cyc.size() - sb, 1);

    // Burst of three on requester 2 under a single CS window.
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
    sb = start_cyc.size(); rb = rx_dat.size(); gb = gnt_log.size(); fb = cs_fall.size();
    sl_xor = 8'hF0;
    req[2] = 1'b1;
    tx_valid[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tx_data[2] = burst[k];
      tx_last[2] = (k == 2);
      wait_accept(2);
    end
    tx_valid[2] = 1'b0;
    wait_cnt(1, rb + 3);
    req[2] = 1'b0;
    wait_idle();
    chk("t2_gnt", gnt_log[gb], 2);
    chk("t2_cs_windows", cs_fall.size() - fb, 1);
    chk("t2_starts", start_cyc.size() - sb, 3);
    chk("t2_mosi0", mosi[sb], 8'h11);
    chk("t2_mosi1", mosi[sb + 1], 8'h22);
    chk("t2_mosi2", mosi[sb + 2], 8'h33);
    chk("t2_rx0", rx_dat[rb], 8'hE1);
    chk("t2_rx1", rx_dat[rb + 1], 8'hD2);
    chk("t2_rx2", rx_dat[rb + 2], 8'hC3);
    chk("t2_rx_idx", rx_idx[rb + 2], 2);

    // Round robin from a fresh pointer with all four requesting.
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    sb = start_cyc.size(); gb = gnt_log.size();
    sl_xor = 8'h00;
    for (int i = 0; i < N; i++) tx_data[i] = 8'h40 + 8'(i);
    req = 4'b1111; tx_valid = 4'b1111; tx_last = 4'b1111;
    wait_cnt(2, gb + 5);
    req = '0; tx_valid = '0;
    wait_idle();
    chk("t3_g0", gnt_log[gb], 0);
    chk("t3_g1", gnt_log[gb + 1], 1);
    chk("t3_g2", gnt_log[gb + 2], 2);
    chk("t3_g3", gnt_log[gb + 3], 3);
    chk("t3_g4", gnt_log[gb + 4], 0);
    chk("t3_starts", start_cyc.size() - sb, 4);
    chk("t3_mosi1", mosi[sb + 1], 8'h41);
    chk("t3_mosi3", mosi[sb + 3], 8'h43);

    // Mode switch between owners.
    sb = start_cyc.size(); gb = gnt_log.size();
    do_single(1, 1'b1, 1'b1, 8'h5A, 8'h96);
    do_single(3, 1'b0, 1'b0, 8'hC7, 8'h7C);
    chk("t4_gnt_a", gnt_log[gb], 1);
    chk("t4_gnt_b", gnt_log[gb + 1], 3);
    chk("t4_mode_a", mode_q[sb], 2'b11);
    chk("t4_mode_b", mode_q[sb + 1], 2'b00);

    // Stall then drop, with a foreign request arriving mid-burst.
    sb = start_cyc.size(); rb = rx_dat.size(); gb = gnt_log.size(); ab = acc_cnt;
    sl_xor = 8'h00;
    tx_data[0] = 8'h77; tx_last[0] = 1'b0; tx_valid[0] = 1'b1; req[0] = 1'b1;
    wait_accept(0);
    tx_valid[0] = 1'b0;
    tx_data[3] = 8'h99; tx_last[3] = 1'b1; tx_valid[3] = 1'b1; req[3] = 1'b1;
    repeat (20) step();
    chk("t5_stall_starts", start_cyc.size() - sb, 1);
    chk("t5_stall_cs", cs_n, 4'b1110);
    chk("t5_stall_gnt", gnt, 4'b0001);
    chk("t5_stall_rx", rx_dat.size() - rb, 1);
    req[0] = 1'b0;
    wait_cnt(1, rb + 2);
    req[3] = 1'b0; tx_valid[3] = 1'b0;
    wait_idle();
    chk("t5_gnt_next", gnt_log[gb + 1], 3);
    chk("t5_starts", start_cyc.size() - sb, 2);
    chk("t5_mosi", mosi[sb + 1], 8'h99);
    chk("t5_accepts", acc_cnt - ab, 2);

    // Reset while a byte is in flight.
    do_single(1, 1'b0, 1'b0, 8'h12, 8'h34);
    sb = start_cyc.size(); rb = rx_dat.size(); gb = gnt_log.size();
    tx_data[2] = 8'hAB; tx_last[2] = 1'b1; tx_valid[2] = 1'b1; req[2] = 1'b1;
    wait_cnt(0, sb + 1);
    reset = 1'b0; req[2] = 1'b0; tx_valid[2] = 1'b0;
    step();
    reset = 1'b1;
    chk("t6_cs_n", cs_n, 4'hF);
    chk("t6_gnt", gnt, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rx_data", rx_data, 0);
    repeat (10) step();
    chk("t6_no_rx", rx_dat.size() - rb, 0);
    req = 4'b0110;
    wait_cnt(2, gb + 2);
    req = '0;
    wait_idle();
    chk("t6_ptr_reset", gnt_log[gb + 1], 1);

    chk("invariants", inv_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
